// File: rtl/stream_req_pkg.sv
// Shared sizing, per-stream state record and helpers for the stream request generator.
package stream_req_pkg;

    localparam int ADDR_WIDTH   = 64;
    localparam int DATA_WIDTH   = 1024;
    localparam int NSTRMS       = 64;
    localparam int NSTRMS_WIDTH = $clog2(NSTRMS);
    localparam int NCL_WIDTH    = 16;
    localparam int STRM_DEPTH   = 4;
    localparam int CRD_WIDTH    = $clog2(STRM_DEPTH + 1);
    localparam int CL_BYTES     = DATA_WIDTH / 8;
    localparam int CL_OFF       = $clog2(CL_BYTES);

    typedef struct packed {
        logic                  act;
        logic                  dpend;
        logic [ADDR_WIDTH-1:0] ea;
        logic [NCL_WIDTH-1:0]  rem;
        logic [CRD_WIDTH-1:0]  crd;
    } strm_state_t;

    localparam strm_state_t STRM_RESET = '{
        act:   1'b0,
        dpend: 1'b0,
        ea:    '0,
        rem:   '0,
        crd:   CRD_WIDTH'(STRM_DEPTH)
    };

    function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] ea);
        return ea & ~ADDR_WIDTH'(CL_BYTES - 1);
    endfunction

endpackage

// File: rtl/stream_req_gen_if.sv
// Command, credit, request and done channels of the stream request generator.
interface stream_req_gen_if;
    import stream_req_pkg::*;

    logic                    i_cmd_v;
    logic                    i_cmd_r;
    logic [NSTRMS_WIDTH-1:0] i_cmd_sid;
    logic [ADDR_WIDTH-1:0]   i_cmd_ea;
    logic [NCL_WIDTH-1:0]    i_cmd_ncl;
    logic                    i_crd_v;
    logic [NSTRMS_WIDTH-1:0] i_crd_sid;
    logic                    o_req_v;
    logic                    o_req_r;
    logic [NSTRMS_WIDTH-1:0] o_req_sid;
    logic [ADDR_WIDTH-1:0]   o_req_ea;
    logic                    o_done_v;
    logic                    o_done_r;
    logic [NSTRMS_WIDTH-1:0] o_done_sid;
    logic [NSTRMS-1:0]       o_busy;
    logic                    o_err;

    modport slave (
        input  i_cmd_v, i_cmd_sid, i_cmd_ea, i_cmd_ncl, i_crd_v, i_crd_sid, o_req_r, o_done_r,
        output i_cmd_r, o_req_v, o_req_sid, o_req_ea, o_done_v, o_done_sid, o_busy, o_err
    );

    modport master (
        output i_cmd_v, i_cmd_sid, i_cmd_ea, i_cmd_ncl, i_crd_v, i_crd_sid, o_req_r, o_done_r,
        input  i_cmd_r, o_req_v, o_req_sid, o_req_ea, o_done_v, o_done_sid, o_busy, o_err
    );

endinterface

// File: rtl/stream_rr_arb.sv
// N-way round-robin arbiter: grants the first eligible requester at or after the pointer.
module stream_rr_arb #(
    parameter  int N  = 64,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  elig_i,
    input  logic          accept_i,
    output logic          gnt_v_o,
    output logic [N-1:0]  gnt_oh_o,
    output logic [IW-1:0] gnt_idx_o
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] cand;

    // NOTE: every variable written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        gnt_v_o   = 1'b0;
        gnt_idx_o = '0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            cand = IW'((int'(ptr_q) + i) % N);
            if (!gnt_v_o && elig_i[cand]) begin
                gnt_v_o   = 1'b1;
                gnt_idx_o = cand;
            end
        end
        gnt_oh_o = gnt_v_o ? (N'(1) << gnt_idx_o) : '0;

        ptr_d = ptr_q;
        if (accept_i) begin
            ptr_d = (int'(gnt_idx_o) == N - 1) ? '0 : gnt_idx_o + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/stream_req_gen.sv
// Per-stream cache-line request generator: round-robin over active streams, credit throttled.
module stream_req_gen
    import stream_req_pkg::*;
(
    input logic             clk,
    input logic             reset,
    stream_req_gen_if.slave bus
);

    strm_state_t strm_q [NSTRMS];
    strm_state_t strm_d [NSTRMS];

    logic                    req_v_q, req_v_d;
    logic [NSTRMS_WIDTH-1:0] req_sid_q, req_sid_d;
    logic [ADDR_WIDTH-1:0]   req_ea_q, req_ea_d;
    logic                    err_q, err_d;

    logic [NSTRMS-1:0]       act_vec, dpend_vec, elig;
    logic [NSTRMS-1:0]       gnt_oh, grant, crd_ret, cmd_hit, done_hit;
    logic [NSTRMS_WIDTH-1:0] gnt_idx, done_sid;
    logic                    gnt_v, arb_en, gnt_fire;
    logic                    cmd_r, cmd_fire, done_fire;

    always_comb begin
        for (int s = 0; s < NSTRMS; s++) begin
            act_vec[s]   = strm_q[s].act;
            dpend_vec[s] = strm_q[s].dpend;
            elig[s]      = strm_q[s].act && (strm_q[s].rem != '0) && (strm_q[s].crd != '0);
        end
    end

    // The output register can take a new grant when empty or when its current entry drains.
    assign arb_en   = !req_v_q || bus.o_req_r;
    assign gnt_fire = arb_en && gnt_v;

    stream_rr_arb #(.N(NSTRMS)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .elig_i    (elig),
        .accept_i  (gnt_fire),
        .gnt_v_o   (gnt_v),
        .gnt_oh_o  (gnt_oh),
        .gnt_idx_o (gnt_idx)
    );

    assign cmd_r     = !act_vec[bus.i_cmd_sid] && !dpend_vec[bus.i_cmd_sid];
    assign cmd_fire  = bus.i_cmd_v && cmd_r;
    assign done_fire = (|dpend_vec) && bus.o_done_r;

    always_comb begin
        done_sid = '0;
        for (int s = NSTRMS - 1; s >= 0; s--) begin
            if (dpend_vec[s]) done_sid = NSTRMS_WIDTH'(s);
        end
    end

    assign grant    = gnt_fire ? gnt_oh : '0;
    assign crd_ret  = bus.i_crd_v ? (NSTRMS'(1) << bus.i_crd_sid) : '0;
    assign cmd_hit  = cmd_fire ? (NSTRMS'(1) << bus.i_cmd_sid) : '0;
    assign done_hit = done_fire ? (NSTRMS'(1) << done_sid) : '0;

    always_comb begin
        err_d = err_q;
        for (int s = 0; s < NSTRMS; s++) begin
            strm_d[s] = strm_q[s];

            // A credit arriving with a grant on the same stream cancels out.
            if (crd_ret[s] && strm_q[s].crd == CRD_WIDTH'(STRM_DEPTH)) err_d = 1'b1;
            if (crd_ret[s] && !grant[s]) begin
                if (strm_q[s].crd != CRD_WIDTH'(STRM_DEPTH)) strm_d[s].crd = strm_q[s].crd + 1'b1;
            end else if (grant[s] && !crd_ret[s]) begin
                strm_d[s].crd = strm_q[s].crd - 1'b1;
            end

            if (grant[s]) begin
                strm_d[s].ea  = strm_q[s].ea + ADDR_WIDTH'(CL_BYTES);
                strm_d[s].rem = strm_q[s].rem - 1'b1;
                if (strm_q[s].rem == NCL_WIDTH'(1)) begin
                    strm_d[s].act   = 1'b0;
                    strm_d[s].dpend = 1'b1;
                end
            end

            if (done_hit[s]) strm_d[s].dpend = 1'b0;

            if (cmd_hit[s]) begin
                strm_d[s].ea  = line_align(bus.i_cmd_ea);
                strm_d[s].rem = bus.i_cmd_ncl;
                if (bus.i_cmd_ncl != '0) strm_d[s].act   = 1'b1;
                else                     strm_d[s].dpend = 1'b1;
            end
        end
    end

    always_comb begin
        req_v_d   = req_v_q;
        req_sid_d = req_sid_q;
        req_ea_d  = req_ea_q;
        if (arb_en) begin
            req_v_d = gnt_v;
            if (gnt_v) begin
                req_sid_d = gnt_idx;
                req_ea_d  = strm_q[gnt_idx].ea;
            end
        end
    end

    // NOTE: the state array is flops, not SRAM, so it is reset like any other register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < NSTRMS; s++) strm_q[s] <= STRM_RESET;
            req_v_q   <= 1'b0;
            req_sid_q <= '0;
            req_ea_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            for (int s = 0; s < NSTRMS; s++) strm_q[s] <= strm_d[s];
            req_v_q   <= req_v_d;
            req_sid_q <= req_sid_d;
            req_ea_q  <= req_ea_d;
            err_q     <= err_d;
        end
    end

    assign bus.i_cmd_r    = cmd_r;
    assign bus.o_req_v    = req_v_q;
    assign bus.o_req_sid  = req_sid_q;
    assign bus.o_req_ea   = req_ea_q;
    assign bus.o_done_v   = |dpend_vec;
    assign bus.o_done_sid = done_sid;
    assign bus.o_busy     = act_vec | dpend_vec;
    assign bus.o_err      = err_q;

endmodule

// File: tb/tb_stream_req_gen.sv
// Directed bench for stream_req_gen; expected requests/dones are queued and checked by a monitor.
module tb_stream_req_gen;
    import stream_req_pkg::*;

    typedef struct {
        logic [NSTRMS_WIDTH-1:0] sid;
        logic [ADDR_WIDTH-1:0]   ea;
    } req_exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    req_exp_t                req_q  [$];
    logic [NSTRMS_WIDTH-1:0] done_q [$];

    stream_req_gen_if bus ();

    stream_req_gen dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", name, got, exp);
        end
    endtask

    task automatic push_req(input int sid, input logic [63:0] ea);
        req_exp_t e;
        e.sid = NSTRMS_WIDTH'(sid);
        e.ea  = ea;
        req_q.push_back(e);
    endtask

    // Scoreboard monitor: compares every completed handshake with the head of its queue.
    always @(negedge clk) begin
        if (reset && bus.o_req_v && bus.o_req_r) begin
            checks++;
            if (req_q.size() == 0) begin
                failures++;
                $display("FAIL req_unexpected got sid=%0d ea=%0h required none", bus.o_req_sid, bus.o_req_ea);
            end else begin
                req_exp_t e;
                e = req_q.pop_front();
                if (bus.o_req_sid !== e.sid || bus.o_req_ea !== e.ea) begin
                    failures++;
                    $display("FAIL req got sid=%0d ea=%0h required sid=%0d ea=%0h",
                             bus.o_req_sid, bus.o_req_ea, e.sid, e.ea);
                end
            end
        end
        if (reset && bus.o_done_v && bus.o_done_r) begin
            checks++;
            if (done_q.size() == 0) begin
                failures++;
                $display("FAIL done_unexpected got sid=%0d required none", bus.o_done_sid);
            end else begin
                logic [NSTRMS_WIDTH-1:0] d;
                d = done_q.pop_front();
                if (bus.o_done_sid !== d) begin
                    failures++;
                    $display("FAIL done got sid=%0d required sid=%0d", bus.o_done_sid, d);
                end
            end
        end
    end

    task automatic send_cmd(input int sid, input logic [63:0] ea, input int ncl);
        int n;
        n = 0;
        bus.i_cmd_v   = 1'b1;
        bus.i_cmd_sid = NSTRMS_WIDTH'(sid);
        bus.i_cmd_ea  = ea;
        bus.i_cmd_ncl = NCL_WIDTH'(ncl);
        @(negedge clk);
        while (!bus.i_cmd_r && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL cmd_accept got ready=0 required ready=1 sid=%0d", sid);
        end
        @(posedge clk);
        #1;
        bus.i_cmd_v = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((req_q.size() != 0 || done_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(req_q.size() + done_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req_v(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.o_req_v && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(bus.o_req_v), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b0;
        bus.i_cmd_v   = 1'b0;
        bus.i_cmd_sid = '0;
        bus.i_cmd_ea  = '0;
        bus.i_cmd_ncl = '0;
        bus.i_crd_v   = 1'b0;
        bus.i_crd_sid = '0;
        bus.o_req_r   = 1'b1;
        bus.o_done_r  = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_req_v",  64'(bus.o_req_v),   64'd0);
        check("rst_done_v", 64'(bus.o_done_v),  64'd0);
        check("rst_err",    64'(bus.o_err),     64'd0);
        check("rst_busy",   bus.o_busy,         64'd0);
        check("rst_cmd_r",  64'(bus.i_cmd_r),   64'd1);
        check("rst_req_sid", 64'(bus.o_req_sid), 64'd0);
        check("rst_req_ea", bus.o_req_ea,       64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single stream, unaligned start address.
        push_req(3, 64'h1000);
        push_req(3, 64'h1080);
        push_req(3, 64'h1100);
        done_q.push_back(NSTRMS_WIDTH'(3));
        send_cmd(3, 64'h1005, 3);
        wait_drain("t1_drain");
        check("t1_busy3", 64'(bus.o_busy[3]), 64'd0);
        check("t1_err",   64'(bus.o_err),     64'd0);

        // Credit limit: 4 requests, stall, then 2 credits release the rest.
        for (int i = 0; i < 4; i++) push_req(5, 64'h2000 + 64'(i * 128));
        send_cmd(5, 64'h2000, 6);
        wait_drain("t2_drain4");
        repeat (3) @(negedge clk);
        check("t2_stall_v", 64'(bus.o_req_v),   64'd0);
        check("t2_busy5",   64'(bus.o_busy[5]), 64'd1);
        @(posedge clk);
        #1;
        push_req(5, 64'h2200);
        push_req(5, 64'h2280);
        done_q.push_back(NSTRMS_WIDTH'(5));
        bus.i_crd_v   = 1'b1;
        bus.i_crd_sid = NSTRMS_WIDTH'(5);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        bus.i_crd_v = 1'b0;
        wait_drain("t2_drain");

        // Round robin across three streams.
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < 3; s++) push_req(s, 64'h3000 + 64'(s * 'h1000) + 64'(r * 128));
        for (int s = 0; s < 3; s++) done_q.push_back(NSTRMS_WIDTH'(s));
        for (int s = 0; s < 3; s++) send_cmd(s, 64'h3000 + 64'(s * 'h1000), 2);
        wait_drain("t3_drain");

        // Backpressure: the held request stays stable, then drains back to back.
        bus.o_req_r = 1'b0;
        push_req(7, 64'h6000);
        push_req(7, 64'h6080);
        push_req(7, 64'h6100);
        done_q.push_back(NSTRMS_WIDTH'(7));
        send_cmd(7, 64'h6000, 3);
        wait_req_v("t4_req_v");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_hold_sid", 64'(bus.o_req_sid), 64'd7);
            check("t4_hold_ea",  bus.o_req_ea,       64'h6000);
        end
        @(posedge clk);
        #1;
        bus.o_req_r = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_b2b_v", 64'(bus.o_req_v), 64'd1);
        end
        wait_drain("t4_drain");

        // Credit overflow on an idle stream: error sticks, credit stays at 4.
        bus.i_crd_v   = 1'b1;
        bus.i_crd_sid = NSTRMS_WIDTH'(9);
        @(posedge clk);
        #1;
        bus.i_crd_v = 1'b0;
        @(negedge clk);
        check("t5_err", 64'(bus.o_err), 64'd1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) push_req(9, 64'h9000 + 64'(i * 128));
        send_cmd(9, 64'h9000, 5);
        wait_drain("t5_drain4");
        repeat (3) @(negedge clk);
        check("t5_cap_stall_v", 64'(bus.o_req_v), 64'd0);
        @(posedge clk);
        #1;

        // Zero-length command: done only.
        done_q.push_back(NSTRMS_WIDTH'(10));
        send_cmd(10, 64'hA000, 0);
        wait_drain("t5_ncl0_drain");
        check("t5_busy10",   64'(bus.o_busy[10]), 64'd0);
        check("t5_err_keep", 64'(bus.o_err),      64'd1);

        // Address wrap at the top of the address space.
        push_req(11, 64'hFFFF_FFFF_FFFF_FF80);
        push_req(11, 64'h0);
        done_q.push_back(NSTRMS_WIDTH'(11));
        send_cmd(11, 64'hFFFF_FFFF_FFFF_FF80, 2);
        wait_drain("t6_drain");

        // Reset in the middle of a stream with a request held.
        bus.o_req_r = 1'b0;
        send_cmd(12, 64'hC000, 10);
        wait_req_v("t6_pre_rst_v");
        @(posedge clk);
        #1;
        reset         = 1'b0;
        bus.i_cmd_sid = NSTRMS_WIDTH'(12);
        #1;
        check("t6_rst_req_v",   64'(bus.o_req_v),   64'd0);
        check("t6_rst_done_v",  64'(bus.o_done_v),  64'd0);
        check("t6_rst_err",     64'(bus.o_err),     64'd0);
        check("t6_rst_busy",    bus.o_busy,         64'd0);
        check("t6_rst_cmd_r",   64'(bus.i_cmd_r),   64'd1);
        check("t6_rst_req_sid", 64'(bus.o_req_sid), 64'd0);
        check("t6_rst_req_ea",  bus.o_req_ea,       64'd0);
        @(negedge clk);
        reset       = 1'b1;
        bus.o_req_r = 1'b1;
        @(posedge clk);
        #1;
        bus.i_cmd_sid = NSTRMS_WIDTH'(9);
        #1;
        check("t6_post_cmd_r9", 64'(bus.i_cmd_r), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
